// File: rtl/pc_predict_ras.sv
// rtl/pc_predict_ras.sv - fetch PC predictor with mispredict correction and return-address stack
// The return-address stack is built only when PC_PREDICT_RAS_EN is defined.
module pc_predict_ras #(
    parameter int                ADDR_W    = 64,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         f_stall,
    input  logic [3:0]                   f_icode,
    input  logic [ADDR_W-1:0]            f_valC,
    input  logic [ADDR_W-1:0]            f_valP,
    input  logic [3:0]                   m_icode,
    input  logic                         m_cnd,
    input  logic [ADDR_W-1:0]            m_valA,
    input  logic [3:0]                   w_icode,
    input  logic [ADDR_W-1:0]            w_valM,
    input  logic [ADDR_W-1:0]            w_ras_tgt,
    output logic [ADDR_W-1:0]            f_pc,
    output logic [ADDR_W-1:0]            pred_pc,
    output logic [ADDR_W-1:0]            ras_tgt,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         mispredict
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;
    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] ICODE_CALL = 4'h8;
    localparam logic [3:0] ICODE_RET  = 4'h9;

    logic              jmis;
    logic              rmis;
    logic [ADDR_W-1:0] ret_pred;
    logic [ADDR_W-1:0] pred_pc_d, pred_pc_q;

    assign jmis       = (m_icode == ICODE_JXX) && !m_cnd;
    assign mispredict = jmis | rmis;
    assign f_pc       = jmis ? m_valA : (rmis ? w_valM : pred_pc_q);
    assign pred_pc    = pred_pc_q;

    always_comb begin
        pred_pc_d = pred_pc_q;
        if (!f_stall) begin
            case (f_icode)
                ICODE_JXX, ICODE_CALL: pred_pc_d = f_valC;
                ICODE_RET:             pred_pc_d = ret_pred;
                default:               pred_pc_d = f_valP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_pc_q <= RESET_PC;
        end else begin
            pred_pc_q <= pred_pc_d;
        end
    end

`ifdef PC_PREDICT_RAS_EN
    localparam int             PW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [CW-1:0]  FULL = CW'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
    logic [PW-1:0]     ras_ptr_d, ras_ptr_q;
    logic [PW-1:0]     ras_top_idx;
    logic [CW-1:0]     ras_count_d, ras_count_q;
    logic              ras_overflow_d, ras_overflow_q;
    logic [CW-1:0]     base_count;
    logic              ras_we;

    assign rmis         = (w_icode == ICODE_RET) && (w_valM != w_ras_tgt);
    assign ras_top_idx  = ras_ptr_q - 1'b1;
    assign ras_tgt      = (ras_count_q != '0) ? ras_mem_q[ras_top_idx] : '0;
    assign ret_pred     = (ras_count_q != '0) ? ras_tgt : f_valP;
    assign ras_count    = ras_count_q;
    assign ras_overflow = ras_overflow_q;

    // A mispredict flushes first; the fetched call then pushes onto the empty stack.
    always_comb begin
        ras_ptr_d      = ras_ptr_q;
        ras_count_d    = ras_count_q;
        ras_overflow_d = ras_overflow_q;
        ras_we         = 1'b0;
        base_count     = mispredict ? '0 : ras_count_q;
        if (!f_stall) begin
            ras_count_d = base_count;
            if (f_icode == ICODE_CALL) begin
                ras_we    = 1'b1;
                ras_ptr_d = ras_ptr_q + 1'b1;
                if (base_count == FULL) begin
                    ras_overflow_d = 1'b1;
                end else begin
                    ras_count_d = base_count + 1'b1;
                end
            end else if ((f_icode == ICODE_RET) && (base_count != '0)) begin
                ras_ptr_d   = ras_ptr_q - 1'b1;
                ras_count_d = base_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_ptr_q      <= '0;
            ras_count_q    <= '0;
            ras_overflow_q <= 1'b0;
        end else begin
            ras_ptr_q      <= ras_ptr_d;
            ras_count_q    <= ras_count_d;
            ras_overflow_q <= ras_overflow_d;
        end
    end

    // Entry storage is never cleared; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (ras_we && !reset) begin
            ras_mem_q[ras_ptr_q] <= f_valP;
        end
    end
`else
    logic unused_ras_tgt;

    assign rmis           = (w_icode == ICODE_RET);
    assign ret_pred       = f_valP;
    assign ras_tgt        = '0;
    assign ras_count      = '0;
    assign ras_overflow   = 1'b0;
    assign unused_ras_tgt = ^w_ras_tgt;
`endif

endmodule

// File: tb/tb_pc_predict_ras.sv
// tb/tb_pc_predict_ras.sv - scoreboard bench for pc_predict_ras in either build of the stack
module tb_pc_predict_ras;
    localparam int AW    = 64;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef PC_PREDICT_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          f_stall;
    logic [3:0]    f_icode;
    logic [AW-1:0] f_valC, f_valP;
    logic [3:0]    m_icode;
    logic          m_cnd;
    logic [AW-1:0] m_valA;
    logic [3:0]    w_icode;
    logic [AW-1:0] w_valM, w_ras_tgt;
    logic [AW-1:0] f_pc, pred_pc, ras_tgt;
    logic [CW-1:0] ras_count;
    logic          ras_overflow, mispredict;

    pc_predict_ras #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .f_stall(f_stall), .f_icode(f_icode),
        .f_valC(f_valC), .f_valP(f_valP), .m_icode(m_icode), .m_cnd(m_cnd),
        .m_valA(m_valA), .w_icode(w_icode), .w_valM(w_valM), .w_ras_tgt(w_ras_tgt),
        .f_pc(f_pc), .pred_pc(pred_pc), .ras_tgt(ras_tgt), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .mispredict(mispredict)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            passed = 0;
    logic [AW-1:0] exp_pc_q [$];
    logic [CW-1:0] exp_cnt_q [$];
    logic [AW-1:0] e_pc;
    logic [CW-1:0] e_cnt;
    logic [AW-1:0] held_pc;

    task automatic fetch(input logic [3:0] ic, input logic [AW-1:0] valc, input logic [AW-1:0] valp);
        f_icode = ic;
        f_valC  = valc;
        f_valP  = valp;
    endtask

    task automatic quiet_pipe();
        m_icode = 4'h0; m_cnd = 1'b1; m_valA = '0;
        w_icode = 4'h0; w_valM = '0; w_ras_tgt = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; f_stall = 1'b0; quiet_pipe();
        fetch(4'h1, '0, 64'h0A);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pred_pc !== 64'h0) $display("FAIL reset pred_pc got %0h expected 0", pred_pc); else passed++;
        checks++; if (f_pc !== 64'h0) $display("FAIL reset f_pc got %0h expected 0", f_pc); else passed++;
        checks++; if (ras_count !== '0) $display("FAIL reset ras_count got %0d expected 0", ras_count); else passed++;
        checks++; if (ras_overflow !== 1'b0) $display("FAIL reset ras_overflow got %b expected 0", ras_overflow); else passed++;
        checks++; if (mispredict !== 1'b0) $display("FAIL reset mispredict got %b expected 0", mispredict); else passed++;
        reset = 1'b0;
        exp_pc_q.push_back(64'h0A); exp_cnt_q.push_back('0);
        @(posedge clk); #1;
        e_pc = exp_pc_q.pop_front(); e_cnt = exp_cnt_q.pop_front();
        checks++; if (pred_pc !== e_pc) $display("FAIL release pred_pc got %0h expected %0h", pred_pc, e_pc); else passed++;
        checks++; if (ras_count !== e_cnt) $display("FAIL release ras_count got %0d expected %0d", ras_count, e_cnt); else passed++;
    endtask

    task automatic test_call_ret();
        fetch(4'h8, 64'h100, 64'h20);
        exp_pc_q.push_back(64'h100); exp_cnt_q.push_back(RAS_ON ? CW'(1) : CW'(0));
        @(posedge clk); #1;
        fetch(4'h9, '0, 64'h33);
        exp_pc_q.push_back(RAS_ON ? 64'h20 : 64'h33); exp_cnt_q.push_back('0);
        e_pc = exp_pc_q.pop_front(); e_cnt = exp_cnt_q.pop_front();
        checks++; if (pred_pc !== e_pc) $display("FAIL call pred_pc got %0h expected %0h", pred_pc, e_pc); else passed++;
        checks++; if (ras_count !== e_cnt) $display("FAIL call ras_count got %0d expected %0d", ras_count, e_cnt); else passed++;
        @(posedge clk); #1;
        e_pc = exp_pc_q.pop_front(); e_cnt = exp_cnt_q.pop_front();
        checks++; if (pred_pc !== e_pc) $display("FAIL ret pred_pc got %0h expected %0h", pred_pc, e_pc); else passed++;
        checks++; if (ras_count !== e_cnt) $display("FAIL ret ras_count got %0d expected %0d", ras_count, e_cnt); else passed++;
    endtask

    task automatic test_jmp_mispredict();
        logic [3:0]    ics  [5] = '{4'h8, 4'h7, 4'h1, 4'h8, 4'h9};
        logic [AW-1:0] vcs  [5] = '{64'h200, 64'h40, 64'h0, 64'h700, 64'h0};
        logic [AW-1:0] vps  [5] = '{64'h24, 64'h25, 64'h2C, 64'h71, 64'h72};
        logic [AW-1:0] eps  [5];
        logic [CW-1:0] ecs  [5];
        eps = '{64'h200, 64'h40, 64'h2C, 64'h700, RAS_ON ? 64'h71 : 64'h72};
        ecs = '{CW'(RAS_ON), CW'(RAS_ON), CW'(0), CW'(RAS_ON), CW'(0)};
        for (int i = 0; i < 5; i++) begin
            fetch(ics[i], vcs[i], vps[i]);
            if (i == 2) begin
                m_icode = 4'h7; m_cnd = 1'b1; m_valA = 64'h2B; #1;
                checks++; if (f_pc !== 64'h40) $display("FAIL jxx_taken f_pc got %0h expected 40", f_pc); else passed++;
                checks++; if (mispredict !== 1'b0) $display("FAIL jxx_taken mispredict got %b expected 0", mispredict); else passed++;
                m_cnd = 1'b0; #1;
                checks++; if (f_pc !== 64'h2B) $display("FAIL jmis f_pc got %0h expected 2b", f_pc); else passed++;
                checks++; if (mispredict !== 1'b1) $display("FAIL jmis mispredict got %b expected 1", mispredict); else passed++;
            end
            if (i == 4) quiet_pipe();
            exp_pc_q.push_back(eps[i]); exp_cnt_q.push_back(ecs[i]);
            @(posedge clk); #1;
            e_pc = exp_pc_q.pop_front(); e_cnt = exp_cnt_q.pop_front();
            checks++; if (pred_pc !== e_pc) $display("FAIL jmp step %0d pred_pc got %0h expected %0h", i, pred_pc, e_pc); else passed++;
            checks++; if (ras_count !== e_cnt) $display("FAIL jmp step %0d ras_count got %0d expected %0d", i, ras_count, e_cnt); else passed++;
        end
        held_pc = eps[4];
    endtask

    task automatic test_ret_priority();
        f_stall = 1'b1;
        w_icode = 4'h9; w_valM = 64'h300; w_ras_tgt = 64'h200; #1;
        checks++; if (f_pc !== 64'h300) $display("FAIL rmis f_pc got %0h expected 300", f_pc); else passed++;
        checks++; if (mispredict !== 1'b1) $display("FAIL rmis mispredict got %b expected 1", mispredict); else passed++;
        m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h50; #1;
        checks++; if (f_pc !== 64'h50) $display("FAIL jmis_over_rmis f_pc got %0h expected 50", f_pc); else passed++;
        m_icode = 4'h0; w_valM = 64'h200; #1;
        e_pc = RAS_ON ? held_pc : 64'h200;
        checks++; if (f_pc !== e_pc) $display("FAIL ret_match f_pc got %0h expected %0h", f_pc, e_pc); else passed++;
        checks++; if (mispredict !== !RAS_ON) $display("FAIL ret_match mispredict got %b expected %b", mispredict, !RAS_ON); else passed++;
        @(posedge clk); #1;
        checks++; if (pred_pc !== held_pc) $display("FAIL stalled_mispredict pred_pc got %0h expected %0h", pred_pc, held_pc); else passed++;
        quiet_pipe();
    endtask

    task automatic test_stall();
        f_stall = 1'b1;
        fetch(4'h8, 64'h500, 64'h60);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) f_stall = 1'b0;
            if (i == 4) fetch(4'h9, '0, 64'h77);
            exp_pc_q.push_back(i < 3 ? held_pc : (i == 3 ? 64'h500 : (RAS_ON ? 64'h60 : 64'h77)));
            exp_cnt_q.push_back(i == 3 ? CW'(RAS_ON) : CW'(0));
            @(posedge clk); #1;
            e_pc = exp_pc_q.pop_front(); e_cnt = exp_cnt_q.pop_front();
            checks++; if (pred_pc !== e_pc) $display("FAIL stall step %0d pred_pc got %0h expected %0h", i, pred_pc, e_pc); else passed++;
            checks++; if (ras_count !== e_cnt) $display("FAIL stall step %0d ras_count got %0d expected %0d", i, ras_count, e_cnt); else passed++;
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            fetch(4'h8, 64'h1000 + AW'(i), 64'h10 + AW'(i));
            exp_pc_q.push_back(64'h1000 + AW'(i));
            exp_cnt_q.push_back(RAS_ON ? CW'((i < 8) ? i + 1 : 8) : CW'(0));
            @(posedge clk); #1;
            e_pc = exp_pc_q.pop_front(); e_cnt = exp_cnt_q.pop_front();
            checks++; if (pred_pc !== e_pc) $display("FAIL push %0d pred_pc got %0h expected %0h", i, pred_pc, e_pc); else passed++;
            checks++; if (ras_count !== e_cnt) $display("FAIL push %0d ras_count got %0d expected %0d", i, ras_count, e_cnt); else passed++;
        end
        checks++; if (ras_overflow !== RAS_ON) $display("FAIL overflow flag got %b expected %b", ras_overflow, RAS_ON); else passed++;
        for (int i = 0; i < 9; i++) begin
            e_pc = (RAS_ON && i < 8) ? 64'h18 - AW'(i) : 64'h0;
            checks++; if (ras_tgt !== e_pc) $display("FAIL pop %0d ras_tgt got %0h expected %0h", i, ras_tgt, e_pc); else passed++;
            fetch(4'h9, '0, 64'h900 + AW'(i));
            exp_pc_q.push_back((RAS_ON && i < 8) ? 64'h18 - AW'(i) : 64'h900 + AW'(i));
            exp_cnt_q.push_back((RAS_ON && i < 8) ? CW'(7 - i) : CW'(0));
            @(posedge clk); #1;
            e_pc = exp_pc_q.pop_front(); e_cnt = exp_cnt_q.pop_front();
            checks++; if (pred_pc !== e_pc) $display("FAIL pop %0d pred_pc got %0h expected %0h", i, pred_pc, e_pc); else passed++;
            checks++; if (ras_count !== e_cnt) $display("FAIL pop %0d ras_count got %0d expected %0d", i, ras_count, e_cnt); else passed++;
        end
        checks++; if (ras_overflow !== RAS_ON) $display("FAIL overflow sticky got %b expected %b", ras_overflow, RAS_ON); else passed++;
    endtask

    task automatic test_reset_mid();
        fetch(4'h8, 64'hA00, 64'hA4);
        @(posedge clk); #1;
        reset = 1'b1; f_stall = 1'b1;
        m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h55;
        @(posedge clk); #1;
        reset = 1'b0; quiet_pipe();
        checks++; if (pred_pc !== 64'h0) $display("FAIL reset_mid pred_pc got %0h expected 0", pred_pc); else passed++;
        checks++; if (ras_count !== '0) $display("FAIL reset_mid ras_count got %0d expected 0", ras_count); else passed++;
        checks++; if (ras_overflow !== 1'b0) $display("FAIL reset_mid ras_overflow got %b expected 0", ras_overflow); else passed++;
        checks++; if (ras_tgt !== 64'h0) $display("FAIL reset_mid ras_tgt got %0h expected 0", ras_tgt); else passed++;
        f_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_jmp_mispredict();
        test_ret_priority();
        test_stall();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/pc_predict_ras.md
PC_PREDICT_RAS -- requirements
Module: pc_predict_ras

Interface
REQ-001 Parameter ADDR_W, default 64: width of every address/PC bus.
REQ-002 Parameter RAS_DEPTH, default 8: return-address-stack entries, power of two, 2..64.
REQ-003 Parameter RESET_PC, default 0: value of pred_pc after reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 f_stall  input  1  fetch stall; 1 holds pred_pc and RAS.
REQ-007 f_icode  input  4  icode of the instruction fetched this cycle.
REQ-008 f_valC  input  ADDR_W  constant word (jXX/call target) of the fetched instruction.
REQ-009 f_valP  input  ADDR_W  fall-through address of the fetched instruction.
REQ-010 m_icode  input  4  icode in memory stage.
REQ-011 m_cnd  input  1  condition result of the jXX in memory stage.
REQ-012 m_valA  input  ADDR_W  fall-through address carried by the jXX in memory stage.
REQ-013 w_icode  input  4  icode in write-back stage.
REQ-014 w_valM  input  ADDR_W  actual return address popped by a ret in write-back.
REQ-015 w_ras_tgt  input  ADDR_W  predicted ret target carried down the pipe with that ret.
REQ-016 f_pc  output  ADDR_W  combinational fetch address for this cycle.
REQ-017 pred_pc  output  ADDR_W  registered predicted next PC.
REQ-018 ras_tgt  output  ADDR_W  current RAS top (0 when empty), to be piped with a ret.
REQ-019 ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
REQ-020 ras_overflow  output  1  sticky: a push found the RAS full.
REQ-021 mispredict  output  1  combinational: f_pc is a correction this cycle.

Function
REQ-022 Encodings: jXX=4'h7, call=4'h8, ret=4'h9.
REQ-023 jmis = (m_icode==7 && !m_cnd); rmis = (w_icode==9 && w_valM!=w_ras_tgt); mispredict = jmis|rmis.
REQ-024 f_pc priority: jmis -> m_valA; else rmis -> w_valM; else pred_pc.
REQ-025 Next pred_pc from f_icode: 7 or 8 -> f_valC; 9 with ras_count>0 -> ras_tgt; 9 with empty RAS -> f_valP; all others -> f_valP.
REQ-026 pred_pc, RAS and ras_count update only when f_stall==0; f_stall==1 holds all state, including during mispredict.
REQ-027 call (f_icode==8): push f_valP; write at top pointer, pointer increments modulo RAS_DEPTH.
REQ-028 Push when full: overwrite oldest entry (circular), ras_count stays RAS_DEPTH, ras_overflow set to 1.
REQ-029 ret (f_icode==9) with ras_count>0: pop; pointer decrements modulo RAS_DEPTH, ras_count decrements.
REQ-030 ret with empty RAS: no pop, ras_count stays 0, no underflow wrap.
REQ-031 mispredict with f_stall==0: RAS flushed (ras_count=0) in the same edge; the current fetch's push then applies to the empty stack; its pop is suppressed.
REQ-032 Latency: prediction visible on pred_pc one clk after the fetch; correction visible on f_pc in the same cycle as the mispredict.
REQ-033 Address arithmetic is pass-through only; no adders; widths exactly ADDR_W.

Reset
REQ-034 reset==1 at a rising edge: pred_pc=RESET_PC, ras_count=0, pointer=0, ras_overflow=0; has priority over f_stall and mispredict.
REQ-035 Reset mid-operation discards all RAS contents; entry storage need not be cleared; ras_tgt reads 0 when empty.

Configuration
REQ-036 Macro PC_PREDICT_RAS_EN: defined -> RAS present, behaviour as above.
REQ-037 Not defined -> no RAS storage; ras_count, ras_overflow, ras_tgt tied 0; ret predicts f_valP; rmis = (w_icode==9) unconditionally, so every ret is corrected to w_valM.

Verification
REQ-038 reset, then f_icode=1, f_valP=0x0A -> pred_pc=0x0 during reset, 0x0A one clk after release.
REQ-039 call f_valC=0x100,f_valP=0x20, then ret -> pred_pc 0x100 then 0x20; ras_count 1 then 0.
REQ-040 jXX f_valC=0x40 predicted; later m_icode=7,m_cnd=0,m_valA=0x2B -> f_pc=0x2B, mispredict=1 same cycle, ras_count=0 next clk.
REQ-041 RAS_DEPTH=8, 9 calls f_valP=0x10..0x18, 9 rets -> targets 0x18..0x11, then empty-ret predicts f_valP; ras_overflow=1.
REQ-042 w_icode=9,w_valM=0x300,w_ras_tgt=0x200 -> f_pc=0x300; with m_icode=7,m_cnd=0,m_valA=0x50 same cycle -> f_pc=0x50.
REQ-043 f_stall=1 for 3 clks with call presented -> pred_pc, ras_count unchanged; macro undefined: every ret gives f_pc=w_valM.
